// File: rtl/winocnn_pkg.sv
// rtl/winocnn_pkg.sv - shared scheduler state encoding, tile widths and geometry helpers
package winocnn_pkg;

    localparam int TILE_ADDR_W  = 7;
    localparam int TILE_COORD_W = 4;
    localparam int MAX_DIM      = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        REARM
    } sched_state_t;

    // Zero means a single tile; anything past the buffer geometry is pinned to the edge.
    function automatic logic [TILE_COORD_W-1:0] clamp_dim(input logic [7:0] dim);
        if (dim == 8'd0) begin
            return TILE_COORD_W'(1);
        end else if (dim > 8'(MAX_DIM)) begin
            return TILE_COORD_W'(MAX_DIM);
        end
        return dim[TILE_COORD_W-1:0];
    endfunction

    function automatic logic [TILE_ADDR_W-1:0] tile_index(
        input logic [TILE_COORD_W-1:0] y,
        input logic [TILE_COORD_W-1:0] width,
        input logic [TILE_COORD_W-1:0] x
    );
        return {3'b000, y} * {3'b000, width} + {3'b000, x};
    endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - outstanding-tile credit counter with floor at zero and full flag
module credit_counter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       full
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic dec_eff;

    // A retire with nothing outstanding is a spurious pulse and is dropped.
    assign dec_eff = dec && (count != 4'd0);
    assign full    = (count >= MAX_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (inc && !dec_eff) begin
            count <= count + 4'd1;
        end else if (dec_eff && !inc) begin
            count <= count - 4'd1;
        end
    end

endmodule

// File: rtl/data_tile_scheduler.sv
// rtl/data_tile_scheduler.sv - raster tile walk with credit throttling; DATA_TILE_SCHED_PERF_EN adds a stall counter
module data_tile_scheduler
    import winocnn_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              block_width_i,
    input  logic [7:0]              block_height_i,
    input  logic [3:0]              data_id_i,
    input  logic                    size_type_i,
    input  logic                    data_prepare_i,
    input  logic                    tile_ready_i,
    input  logic                    pe_done_i,
    output logic                    tile_valid_o,
    output logic [TILE_COORD_W-1:0] tile_x_o,
    output logic [TILE_COORD_W-1:0] tile_y_o,
    output logic [TILE_ADDR_W-1:0]  tile_addr_o,
    output logic [3:0]              data_id_o,
    output logic                    size_type_o,
    output logic                    loop_finished_o,
    output logic                    busy_o,
    output logic [15:0]             perf_stall_cnt_o
);

    sched_state_t            state, next_state;
    logic [TILE_COORD_W-1:0] width_q, height_q, tile_x, tile_y;
    logic [3:0]              data_id_q, outstanding;
    logic                    size_type_q, credit_full;
    logic                    tile_valid, handshake, last_x, last_y, start;

    assign start     = (state == IDLE) && data_prepare_i;
    assign handshake = tile_valid && tile_ready_i;
    assign last_x    = (tile_x == width_q - 4'd1);
    assign last_y    = (tile_y == height_q - 4'd1);

    credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
        .clk   (clk),
        .reset (reset),
        .inc   (handshake),
        .dec   (pe_done_i),
        .count (outstanding),
        .full  (credit_full)
    );

    always_comb begin
        next_state      = state;
        tile_valid      = 1'b0;
        loop_finished_o = 1'b0;
        case (state)
            IDLE:  if (data_prepare_i) next_state = ISSUE;
            ISSUE: begin
                tile_valid = !credit_full;
                if (handshake && last_x && last_y) next_state = DRAIN;
            end
            DRAIN: if (outstanding == 4'd0) next_state = DONE;
            DONE: begin
                loop_finished_o = 1'b1;
                next_state      = REARM;
            end
            REARM: if (!data_prepare_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            width_q     <= TILE_COORD_W'(1);
            height_q    <= TILE_COORD_W'(1);
            tile_x      <= '0;
            tile_y      <= '0;
            data_id_q   <= 4'd0;
            size_type_q <= 1'b0;
        end else begin
            state <= next_state;
            if (start) begin
                width_q     <= clamp_dim(block_width_i);
                height_q    <= clamp_dim(block_height_i);
                data_id_q   <= data_id_i;
                size_type_q <= size_type_i;
                tile_x      <= '0;
                tile_y      <= '0;
            end else if (handshake) begin
                // The final tile leaves the coordinates parked on the last position.
                if (!last_x) begin
                    tile_x <= tile_x + 4'd1;
                end else if (!last_y) begin
                    tile_x <= '0;
                    tile_y <= tile_y + 4'd1;
                end
            end
        end
    end

`ifdef DATA_TILE_SCHED_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            stall_cnt <= 16'd0;
        end else if ((state == ISSUE) && !handshake && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt;
`else
    assign perf_stall_cnt_o = 16'd0;
`endif

    assign tile_valid_o = tile_valid;
    assign tile_x_o     = tile_x;
    assign tile_y_o     = tile_y;
    assign tile_addr_o  = tile_index(tile_y, width_q, tile_x);
    assign data_id_o    = data_id_q;
    assign size_type_o  = size_type_q;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_data_tile_scheduler.sv
// tb/tb_data_tile_scheduler.sv - directed self-checking bench for data_tile_scheduler
module tb_data_tile_scheduler;

`ifdef DATA_TILE_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  block_width, block_height;
    logic [3:0]  data_id;
    logic        size_type, data_prepare, tile_ready, pe_done;
    logic        tile_valid;
    logic [3:0]  tile_x, tile_y;
    logic [6:0]  tile_addr;
    logic [3:0]  data_id_out;
    logic        size_type_out, loop_finished, busy;
    logic [15:0] perf_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_tile_scheduler #(.MAX_OUTSTANDING(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .block_width_i    (block_width),
        .block_height_i   (block_height),
        .data_id_i        (data_id),
        .size_type_i      (size_type),
        .data_prepare_i   (data_prepare),
        .tile_ready_i     (tile_ready),
        .pe_done_i        (pe_done),
        .tile_valid_o     (tile_valid),
        .tile_x_o         (tile_x),
        .tile_y_o         (tile_y),
        .tile_addr_o      (tile_addr),
        .data_id_o        (data_id_out),
        .size_type_o      (size_type_out),
        .loop_finished_o  (loop_finished),
        .busy_o           (busy),
        .perf_stall_cnt_o (perf_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_tile(input string tag, input int v, input int x, input int y, input int a);
        check({tag, ".valid"}, 32'(tile_valid), 32'(v));
        check({tag, ".x"}, 32'(tile_x), 32'(x));
        check({tag, ".y"}, 32'(tile_y), 32'(y));
        check({tag, ".addr"}, 32'(tile_addr), 32'(a));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_tile(tag, 0, 0, 0, 0);
        check({tag, ".data_id"}, 32'(data_id_out), 0);
        check({tag, ".size"}, 32'(size_type_out), 0);
        check({tag, ".loop"}, 32'(loop_finished), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".perf"}, 32'(perf_stall_cnt), 0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; block_width = 8'd0; block_height = 8'd0; data_id = 4'd0;
        size_type = 1'b0; data_prepare = 1'b0; tile_ready = 1'b0; pe_done = 1'b0;
        repeat (2) cyc();
        check_idle_outputs("rst");
        reset = 1'b0;

        // 2x2 pass, retire one cycle after each handshake
        block_width = 8'd2; block_height = 8'd2; data_id = 4'd5; size_type = 1'b1;
        data_prepare = 1'b1; tile_ready = 1'b1;
        cyc();
        check("t1.data_id", 32'(data_id_out), 5);
        check("t1.size", 32'(size_type_out), 1);
        check("t1.busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            check_tile($sformatf("t1.tile%0d", i), 1, i % 2, i / 2, i);
            pe_done = (i != 0);
            if (i == 2) begin
                block_width = 8'd7; data_id = 4'd9;
            end
            cyc();
        end
        check("t1.drain_valid", 32'(tile_valid), 0);
        check("t1.drain_data_id", 32'(data_id_out), 5);
        check("t1.drain_loop", 32'(loop_finished), 0);
        pe_done = 1'b1;
        cyc();
        pe_done = 1'b0;
        check("t1.drain0_loop", 32'(loop_finished), 0);
        cyc();
        check("t1.done_loop", 32'(loop_finished), 1);
        cyc();
        // prepare still held: REARM must not start a second pass
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3.rearm%0d_loop", i), 32'(loop_finished), 0);
            check($sformatf("t3.rearm%0d_busy", i), 32'(busy), 1);
            check($sformatf("t3.rearm%0d_valid", i), 32'(tile_valid), 0);
            cyc();
        end
        data_prepare = 1'b0;
        cyc();
        check("t1.idle_busy", 32'(busy), 0);

        // 3x1 pass with two credits, retires withheld
        block_width = 8'd3; block_height = 8'd1; data_id = 4'd3; size_type = 1'b0;
        data_prepare = 1'b1; tile_ready = 1'b1; pe_done = 1'b0;
        cyc();
        check_tile("t2.c0", 1, 0, 0, 0);
        check("t2.data_id", 32'(data_id_out), 3);
        check("t2.size", 32'(size_type_out), 0);
        cyc();
        check_tile("t2.c1", 1, 1, 0, 1);
        cyc();
        check_tile("t2.starved", 0, 2, 0, 2);
        pe_done = 1'b1;
        cyc();
        check_tile("t2.freed", 1, 2, 0, 2);
        check("t2.perf", 32'(perf_stall_cnt), PERF ? 1 : 0);
        pe_done = 1'b0;
        cyc();
        check("t2.drain_valid", 32'(tile_valid), 0);
        check("t2.drain_busy", 32'(busy), 1);
        pe_done = 1'b1;
        cyc();
        check("t2.drain1_loop", 32'(loop_finished), 0);
        cyc();
        check("t2.drain2_loop", 32'(loop_finished), 0);
        pe_done = 1'b0;
        cyc();
        check("t2.done_loop", 32'(loop_finished), 1);
        data_prepare = 1'b0;
        cyc();
        check("t2.rearm_loop", 32'(loop_finished), 0);
        cyc();
        check("t2.idle_busy", 32'(busy), 0);

        // 0x0 geometry behaves as a single tile
        block_width = 8'd0; block_height = 8'd0; data_prepare = 1'b1; tile_ready = 1'b1;
        cyc();
        check_tile("t4.tile", 1, 0, 0, 0);
        cyc();
        check("t4.drain_valid", 32'(tile_valid), 0);
        pe_done = 1'b1;
        cyc();
        pe_done = 1'b0;
        check("t4.drain_loop", 32'(loop_finished), 0);
        cyc();
        check("t4.done_loop", 32'(loop_finished), 1);
        data_prepare = 1'b0;
        cyc();
        cyc();
        check("t4.idle_busy", 32'(busy), 0);

        // 10x10 pass aborted by reset after three tiles
        block_width = 8'd10; block_height = 8'd10; data_id = 4'd7; size_type = 1'b1;
        data_prepare = 1'b1; tile_ready = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check_tile($sformatf("t5.tile%0d", i), 1, i, 0, i);
            pe_done = (i != 0);
            cyc();
        end
        check_tile("t5.pre_reset", 1, 3, 0, 3);
        reset = 1'b1; pe_done = 1'b0; tile_ready = 1'b0;
        cyc();
        check_idle_outputs("t5.rst");
        reset = 1'b0; block_width = 8'd2; block_height = 8'd1; data_id = 4'd4;
        cyc();
        // restart from (0,0) with ready low for five cycles
        for (int k = 0; k < 5; k++) begin
            check_tile($sformatf("t6.stall%0d", k), 1, 0, 0, 0);
            cyc();
        end
        check("t6.perf", 32'(perf_stall_cnt), PERF ? 5 : 0);
        check("t6.data_id", 32'(data_id_out), 4);
        tile_ready = 1'b1;
        cyc();
        // second credit still free proves the abort cleared the counter
        check_tile("t6.tile1", 1, 1, 0, 1);
        cyc();
        check("t6.drain_valid", 32'(tile_valid), 0);
        pe_done = 1'b1;
        cyc();
        cyc();
        pe_done = 1'b0;
        check("t6.drain_loop", 32'(loop_finished), 0);
        cyc();
        check("t6.done_loop", 32'(loop_finished), 1);
        check("t6.perf_hold", 32'(perf_stall_cnt), PERF ? 5 : 0);
        data_prepare = 1'b0;
        cyc();
        cyc();
        check("t6.idle_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
